// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: op encodings, port-owner encoding, request bundle.
package mem_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 2;

   // Memory access size; OP_NONE means no access this cycle
   typedef enum logic [OP_W-1:0] {
      OP_NONE = 2'b00,
      OP_BYTE = 2'b01,
      OP_HALF = 2'b10,
      OP_WORD = 2'b11
   } mem_op_e;

   // Which master currently owns the memory port
   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   // One cycle's worth of memory-port request signals
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [OP_W-1:0]   rdop;
      logic [OP_W-1:0]   wrop;
      logic              rdsign;
   } mem_req_t;

   // True when an op field requests an access
   function automatic logic op_active(input logic [OP_W-1:0] op);
      return op != OP_NONE;
   endfunction

   // Counter width for a terminal count of n, never below one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by the CPU MEM stage and a DMA engine.
// The CPU owns the port by default; the DMA takes it when the CPU is idle or
// after STARVE_LIMIT denied cycles, and gives it back after BURST_MAX beats
// or when it stops requesting. Only the owner decision is registered; grant,
// hold and the memory-side signals are combinational within the cycle.
module mem_port_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned BURST_MAX    = 8
) (
   input  logic              clk,
   input  logic              reset,
   // CPU MEM-stage side
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [OP_W-1:0]   cpu_rdop,
   input  logic [OP_W-1:0]   cpu_wrop,
   input  logic              cpu_rdsign,
   output logic              cpu_hold,
   output logic [DATA_W-1:0] cpu_rdata,
   // DMA side
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   // Memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [OP_W-1:0]   mem_rdop,
   output logic [OP_W-1:0]   mem_wrop,
   output logic              mem_rdsign,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned STARVE_W = cnt_width(STARVE_LIMIT);
   localparam int unsigned BEAT_W   = cnt_width(BURST_MAX);
   // Terminal counts: the last denied cycle and the last beat of a burst
   localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'((STARVE_LIMIT > 0) ? STARVE_LIMIT - 1 : 0);
   localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'((BURST_MAX > 0) ? BURST_MAX - 1 : 0);

   owner_e              owner_q, owner_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;

   logic     cpu_act_c;
   mem_req_t cpu_bus_c;
   mem_req_t dma_bus_c;
   mem_req_t mem_bus_c;

   assign cpu_act_c = op_active(cpu_rdop) | op_active(cpu_wrop);

   // Read data is broadcast; each master qualifies it with its own handshake
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   // Owner and counter registers; reset returns the port to the CPU at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q  <= OWN_CPU;
         starve_q <= '0;
         beat_q   <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
         beat_q   <= beat_d;
      end
   end

   // Owner decision: starvation guard on the CPU side, burst limit on the DMA side
   always_comb begin
      owner_d  = owner_q;
      starve_d = starve_q;
      beat_d   = beat_q;
      unique case (owner_q)
         OWN_CPU: begin
            beat_d = '0;
            if (!dma_req) begin
               starve_d = '0;
            end else if (!cpu_act_c || (starve_q >= STARVE_LAST)) begin
               owner_d  = OWN_DMA;
               starve_d = '0;
            end else begin
               starve_d = STARVE_W'(starve_q + 1'b1);
            end
         end
         OWN_DMA: begin
            starve_d = '0;
            if (!dma_req) begin
               owner_d = OWN_CPU;
               beat_d  = '0;
            end else if (beat_q >= BEAT_LAST) begin
               // Last beat of the burst: the CPU gets at least one cycle next
               owner_d = OWN_CPU;
               beat_d  = '0;
            end else begin
               beat_d = BEAT_W'(beat_q + 1'b1);
            end
         end
         default: begin
            owner_d  = OWN_CPU;
            starve_d = '0;
            beat_d   = '0;
         end
      endcase
   end

   // Request bundles for each master as they would appear on the port
   always_comb begin
      cpu_bus_c        = '0;
      cpu_bus_c.addr   = cpu_addr;
      cpu_bus_c.wdata  = cpu_wdata;
      cpu_bus_c.rdop   = cpu_rdop;
      cpu_bus_c.wrop   = cpu_wrop;
      cpu_bus_c.rdsign = cpu_rdsign;

      // DMA moves whole words; ops stay at none unless the beat is live
      dma_bus_c        = '0;
      dma_bus_c.addr   = dma_addr;
      dma_bus_c.wdata  = dma_wdata;
      dma_bus_c.rdsign = 1'b0;
      dma_bus_c.rdop   = OP_NONE;
      dma_bus_c.wrop   = OP_NONE;
      if (dma_req) begin
         dma_bus_c.rdop = dma_we ? OP_NONE : OP_WORD;
         dma_bus_c.wrop = dma_we ? OP_WORD : OP_NONE;
      end
   end

   // Port mux plus grant/hold; a held CPU access never reaches memory
   always_comb begin
      mem_bus_c = cpu_bus_c;
      dma_gnt   = 1'b0;
      cpu_hold  = 1'b0;
      if (owner_q == OWN_DMA) begin
         mem_bus_c = dma_bus_c;
         dma_gnt   = dma_req;
         cpu_hold  = cpu_act_c;
      end
   end

   assign mem_addr   = mem_bus_c.addr;
   assign mem_wdata  = mem_bus_c.wdata;
   assign mem_rdop   = mem_bus_c.rdop;
   assign mem_wrop   = mem_bus_c.wrop;
   assign mem_rdsign = mem_bus_c.rdsign;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bubble entry, starvation guard,
// burst limit, DMA read data and asynchronous reset mid-burst.
module tb_mem_port_arbiter;
   import mem_bus_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [1:0]  cpu_rdop, cpu_wrop;
   logic        cpu_rdsign;
   logic        cpu_hold;
   logic [31:0] cpu_rdata;
   logic        dma_req, dma_we;
   logic [31:0] dma_addr, dma_wdata;
   logic        dma_gnt;
   logic [31:0] dma_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_rdop, mem_wrop;
   logic        mem_rdsign;
   logic [31:0] mem_rdata;

   int n_total = 0;
   int n_bad   = 0;

   // Hand-derived per-cycle grant patterns (bit i = cycle i)
   logic [19:0] exp_gnt_a;
   logic [15:0] exp_gnt_b;

   mem_port_arbiter #(
      .STARVE_LIMIT(4),
      .BURST_MAX   (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdop  (cpu_rdop),
      .cpu_wrop  (cpu_wrop),
      .cpu_rdsign(cpu_rdsign),
      .cpu_hold  (cpu_hold),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_gnt   (dma_gnt),
      .dma_rdata (dma_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdop  (mem_rdop),
      .mem_wrop  (mem_wrop),
      .mem_rdsign(mem_rdsign),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_gnt_a = 20'b1111_0000_1111_1111_0000;
      exp_gnt_b = 16'b0000_1111_1111_0000;

      reset      = 1'b1;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      cpu_rdop   = OP_NONE;
      cpu_wrop   = OP_NONE;
      cpu_rdsign = 1'b0;
      dma_req    = 1'b0;
      dma_we     = 1'b0;
      dma_addr   = '0;
      dma_wdata  = '0;
      mem_rdata  = 32'h0BAD_F00D;

      // Reset state: CPU passthrough even with a DMA request pending
      repeat (2) @(posedge clk);
      #1;
      cpu_addr   = 32'h0000_0040;
      cpu_wdata  = 32'h1111_2222;
      cpu_rdop   = OP_WORD;
      cpu_rdsign = 1'b1;
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = 32'h0000_0100;
      #4;
      check("rst_gnt",    32'(dma_gnt),    32'd0);
      check("rst_hold",   32'(cpu_hold),   32'd0);
      check("rst_addr",   mem_addr,        32'h0000_0040);
      check("rst_wdata",  mem_wdata,       32'h1111_2222);
      check("rst_rdop",   32'(mem_rdop),   32'd3);
      check("rst_wrop",   32'(mem_wrop),   32'd0);
      check("rst_rdsign", 32'(mem_rdsign), 32'd1);
      check("rst_cpu_rd", cpu_rdata,       32'h0BAD_F00D);
      check("rst_dma_rd", dma_rdata,       32'h0BAD_F00D);

      // Idle CPU, DMA writes: one bubble cycle then back-to-back grants
      next_cycle();
      reset      = 1'b0;
      cpu_rdop   = OP_NONE;
      cpu_rdsign = 1'b0;
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = 32'h0000_0100;
      dma_wdata  = 32'hA5A5_A5A5;
      #4;
      check("bub_gnt",  32'(dma_gnt),  32'd0);
      check("bub_hold", 32'(cpu_hold), 32'd0);
      check("bub_wrop", 32'(mem_wrop), 32'd0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #4;
         check("wr_gnt",   32'(dma_gnt),  32'd1);
         check("wr_hold",  32'(cpu_hold), 32'd0);
         check("wr_wrop",  32'(mem_wrop), 32'd3);
         check("wr_rdop",  32'(mem_rdop), 32'd0);
         check("wr_addr",  mem_addr,      32'h0000_0100);
         check("wr_wdata", mem_wdata,     32'hA5A5_A5A5);
      end

      // DMA still owns the port but stops requesting; CPU load is held off memory
      next_cycle();
      dma_req  = 1'b0;
      cpu_rdop = OP_HALF;
      cpu_addr = 32'h0000_0044;
      #4;
      check("drop_gnt",  32'(dma_gnt),  32'd0);
      check("drop_hold", 32'(cpu_hold), 32'd1);
      check("drop_rdop", 32'(mem_rdop), 32'd0);
      check("drop_wrop", 32'(mem_wrop), 32'd0);

      // Port returned: the held load now goes through
      next_cycle();
      #4;
      check("ret_hold", 32'(cpu_hold), 32'd0);
      check("ret_rdop", 32'(mem_rdop), 32'd2);
      check("ret_addr", mem_addr,      32'h0000_0044);

      // CPU loads every cycle, DMA reads continuously: starve, burst, starve, burst
      next_cycle();
      cpu_rdop   = OP_WORD;
      cpu_addr   = 32'h0000_0300;
      cpu_rdsign = 1'b1;
      dma_req    = 1'b1;
      dma_we     = 1'b0;
      dma_addr   = 32'h0000_0200;
      mem_rdata  = 32'h1234_5678;
      for (int i = 0; i < 20; i++) begin
         if (i != 0) next_cycle();
         #4;
         check($sformatf("st_gnt%0d", i),  32'(dma_gnt),  32'(exp_gnt_a[i]));
         check($sformatf("st_hold%0d", i), 32'(cpu_hold), 32'(exp_gnt_a[i]));
         check($sformatf("st_addr%0d", i), mem_addr,
               exp_gnt_a[i] ? 32'h0000_0200 : 32'h0000_0300);
         check($sformatf("st_sign%0d", i), 32'(mem_rdsign), 32'(!exp_gnt_a[i]));
         check($sformatf("st_rdop%0d", i), 32'(mem_rdop), 32'd3);
         if (exp_gnt_a[i]) check("st_dma_rdata", dma_rdata, 32'h1234_5678);
      end

      // Release the second burst early; DMA owns one more non-granting cycle
      next_cycle();
      dma_req  = 1'b0;
      cpu_rdop = OP_NONE;
      #4;
      check("rel_gnt",  32'(dma_gnt),  32'd0);
      check("rel_rdop", 32'(mem_rdop), 32'd0);

      // New write burst from an idle CPU, reset asserted during the third grant
      next_cycle();
      cpu_rdsign = 1'b0;
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = 32'h0000_0400;
      dma_wdata  = 32'h0000_CAFE;
      #4;
      check("b2_bub", 32'(dma_gnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #4;
         check("b2_gnt", 32'(dma_gnt), 32'd1);
      end
      #1;
      reset     = 1'b1;
      cpu_wrop  = OP_HALF;
      cpu_addr  = 32'h0000_0500;
      cpu_wdata = 32'h0000_DEAD;
      #1;
      check("mid_gnt",   32'(dma_gnt),  32'd0);
      check("mid_hold",  32'(cpu_hold), 32'd0);
      check("mid_addr",  mem_addr,      32'h0000_0500);
      check("mid_wdata", mem_wdata,     32'h0000_DEAD);
      check("mid_wrop",  32'(mem_wrop), 32'd2);

      // After release both counters start from zero: 4 denied, 8 beats, CPU again
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i != 0) next_cycle();
         #4;
         check($sformatf("pr_gnt%0d", i),  32'(dma_gnt),  32'(exp_gnt_b[i]));
         check($sformatf("pr_hold%0d", i), 32'(cpu_hold), 32'(exp_gnt_b[i]));
         check($sformatf("pr_wrop%0d", i), 32'(mem_wrop), exp_gnt_b[i] ? 32'd3 : 32'd2);
         check($sformatf("pr_addr%0d", i), mem_addr,
               exp_gnt_b[i] ? 32'h0000_0400 : 32'h0000_0500);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
